// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder
package dmem_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with one synchronous write port and one registered read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: FSM-driven data RAM with programmable wait states and a one-cycle dReady pulse
// Optional DMEM_MISALIGN_ERR_EN adds dError and suppresses misaligned accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       dAddress,
    input  logic [WORD_W-1:0] dWriteData,
    output logic [WORD_W-1:0] dReadData,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic              dError,
`endif
    output logic              dReady
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    state_t            state, state_nxt;
    logic [3:0]        cnt;
    op_t               op_q, op_cur;
    logic [ADDR_W-1:0] idx_q, idx_cur;
    logic [WORD_W-1:0] data_q, data_cur, rd_data;
    logic              mis_q, mis_cur, req, idle, we;
    logic              unused_addr;
    assign unused_addr = ^dAddress[31:ADDR_W+2];
    // In IDLE the live inputs stand in for the capture registers so a zero-wait access hits the RAM on the capture edge.
    always_comb begin
        req       = MemRead | MemWrite;
        idle      = state == IDLE;
        op_cur    = idle ? (MemWrite ? OP_WRITE : OP_READ) : op_q;
        idx_cur   = idle ? dAddress[ADDR_W+1:2] : idx_q;
        data_cur  = idle ? dWriteData : data_q;
        state_nxt = idle ? (req ? (WS != 4'd0 ? WAIT : RESP) : IDLE)
                  : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
        we        = !rst && state != RESP && state_nxt == RESP && op_cur == OP_WRITE && !mis_cur;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (idle && req) ? WS : (state == WAIT ? cnt - 4'd1 : cnt);
        end
        if (idle && req) begin
            op_q   <= op_cur;
            idx_q  <= idx_cur;
            data_q <= data_cur;
        end
    end
`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_cur = idle ? |dAddress[1:0] : mis_q;
    always_ff @(posedge clk) begin
        if (rst) mis_q <= 1'b0;
        else if (idle && req) mis_q <= mis_cur;
    end
    assign dError = state == RESP && mis_q;
`else
    logic unused_lsb;
    assign unused_lsb = ^dAddress[1:0];
    assign mis_cur    = 1'b0;
    assign mis_q      = 1'b0;
`endif
    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk  (clk),
        .we   (we),
        .addr (idx_cur),
        .wdata(data_cur),
        .rdata(rd_data)
    );
    assign dReady    = state == RESP;
    assign dReadData = (state == RESP && op_q == OP_READ && !mis_q) ? rd_data : '0;
endmodule
